core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32 datapath (alu, data_memory, registerFile, instructionMemory,
//  controlLogicGenerator, immediateGenerator). Replaces the free-running two-phase clock scheme with
//  one clock plus explicit strobes. Owns PC, the instruction register and all write/read enables.
//  Adds halt detection, run/stop and a memory wait handshake.
// PARAMETERS
//  PC_W    4   PC width; word index into instructionMemory
//  XLEN    32  datapath/instruction width
//  CNT_W   16  retired-instruction counter width
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  rst_n          in   1       synchronous reset, active low
//  run            in   1       1 = execute; 0 = stop at next instruction boundary
//  instr_in       in   XLEN    instructionMemory data, combinational on pc
//  ctl_branch     in   1       from controlLogicGenerator, decoded from ir
//  ctl_mem_read   in   1       "
//  ctl_mem_write  in   1       "
//  ctl_reg_write  in   1       "
//  alu_zero       in   1       ALU zero flag
//  imm_val        in   XLEN    immediateGenerator output, byte offset
//  mem_ready      in   1       data_memory access complete this cycle
//  pc             out  PC_W    instruction address
//  ir             out  XLEN    latched instruction; drives decode/regfile/immgen
//  reg_we         out  1       registerFile write strobe, one cycle
//  mem_re, mem_we out  1       data_memory strobes, held until mem_ready
//  busy           out  1       1 in any state except IDLE/HALT
//  halted         out  1       1 in HALT
//  retired        out  CNT_W   retired-instruction count, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, pc=0, ir=0, all strobes 0, busy=0, halted=0, retired=0.
//  Reset mid-access drops mem_we/mem_re on that same edge; no partial write is retried.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//   IDLE:   run=1 -> FETCH.
//   FETCH:  ir<=instr_in. instr_in[6:0]==7'h7F -> HALT: pc unchanged, not counted. Otherwise -> DECODE.
//   DECODE: one settle cycle for regfile read -> EXEC.
//   EXEC:   ctl_mem_read|ctl_mem_write -> MEM. Else ctl_reg_write -> WB. Else retire -> FETCH/IDLE.
//   MEM:    mem_re=ctl_mem_read, mem_we=ctl_mem_write; held stable while mem_ready=0, no timeout.
//           On mem_ready: load -> WB; store -> retire.
//   WB:     reg_we=1 for exactly this cycle; retire.
//   HALT:   sticky; only rst_n leaves it. run is ignored.
//  Retire (single edge): pc<=next_pc; retired+=1, saturating at all-ones; next state FETCH if run=1, else IDLE.
//  next_pc: ctl_branch&alu_zero ? pc+imm_val[PC_W+1:2] : pc+1. Both wrap modulo 2^PC_W;
//   pc=15 +1 -> 0. Negative imm wraps the same way.
//  run falling mid-instruction: the instruction completes, then IDLE. run rising in IDLE -> FETCH next edge.
//  Latency (mem_ready=1 immediately): branch/no-write 3 cycles; ALU op 4; store 4; load 5. Add 1 cycle per mem_ready=0 cycle.
//  Strobes are registered outputs decoded from the next state; no combinational path from inputs to strobes.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds input step_req (1 bit). FETCH waits with ir held until step_req=1,
//   so each step_req-high cycle admits one instruction. busy=1 while waiting.
//  SINGLE_STEP_EN undefined: no step_req port; FETCH never waits.
// STRUCTURE
//  Package core_seq_pkg: state enum, HALT_OPCODE=7'h7F, opcode field localparams, default widths.
//  Sub-module core_seq_next_pc: combinational next-PC/branch resolve. All else in one FSM file.
// TESTING
//  1 Reset then run=1; program addi x1,x0,5 then 0x0000007F -> reg_we pulses once at cycle 4;
//    halted=1; pc=1; retired=1.
//  2 sw then lw with mem_ready low 3 cycles -> mem_we held 4 cycles, data stable; load reg_we one cycle after mem_ready.
//  3 beq taken with imm=-8 at pc=1 -> pc=15 (wrap); not-taken at pc=15 -> pc=0.
//  4 run dropped during EXEC of an ALU op -> WB completes, state IDLE, pc advanced by 1, busy=0.
//  5 rst_n=0 during MEM with mem_we=1 -> next edge mem_we=0, pc=0, retired=0, state IDLE.
//  6 SINGLE_STEP_EN: three step_req pulses spaced 10 cycles apart -> exactly 3 retires, FETCH stalls between pulses.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types, widths and opcode constants for the RV32 multi-cycle sequencer.
package core_seq_pkg;

  localparam int unsigned PC_W_DEF  = 4;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 16;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 7'h7F;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/core_seq_next_pc.sv
// Next-PC resolve: taken branches add the word-scaled immediate, everything else steps by one.
// Both paths wrap modulo 2^PC_W.
module core_seq_next_pc
  import core_seq_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF,
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            ctl_branch,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] imm_val,
  output logic [PC_W-1:0] next_pc
);

  // imm_val is a byte offset; only the word-index bits that fit the PC matter.
  logic [PC_W-1:0] imm_words;
  logic            unused_imm;

  assign imm_words  = imm_val[PC_W+1:2];
  assign unused_imm = ^{imm_val[XLEN-1:PC_W+2], imm_val[1:0]};

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (ctl_branch && alu_zero) begin
      next_pc = pc + imm_words;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32 datapath: owns PC, IR and all strobes, with halt and run/stop.
// Optional SINGLE_STEP_EN adds step_req, which gates each instruction fetch.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
`ifdef SINGLE_STEP_EN
  input  logic             step_req,
`endif
  input  logic [XLEN-1:0]  instr_in,
  input  logic             ctl_branch,
  input  logic             ctl_mem_read,
  input  logic             ctl_mem_write,
  input  logic             ctl_reg_write,
  input  logic             alu_zero,
  input  logic [XLEN-1:0]  imm_val,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic [XLEN-1:0]  ir,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  next_pc;
  logic [XLEN-1:0]  ir_q;
  logic             reg_we_q, mem_re_q, mem_we_q;
  logic             busy_q, halted_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             step_ok;

`ifdef SINGLE_STEP_EN
  assign step_ok = step_req;
`else
  assign step_ok = 1'b1;
`endif

  core_seq_next_pc #(
    .PC_W (PC_W),
    .XLEN (XLEN)
  ) u_next_pc (
    .pc         (pc_q),
    .ctl_branch (ctl_branch),
    .alu_zero   (alu_zero),
    .imm_val    (imm_val),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (step_ok) begin
          state_d = is_halt(instr_in[OPCODE_LSB +: OPCODE_W]) ? StHalt : StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (ctl_mem_read || ctl_mem_write) state_d = StMem;
        else if (ctl_reg_write)            state_d = StWb;
        else                               retire  = 1'b1;
      end
      StMem: begin
        // Load vs store is taken from the held strobe so a late ctl change cannot misroute it.
        if (mem_ready) begin
          if (mem_re_q) state_d = StWb;
          else          retire  = 1'b1;
        end
      end
      StWb:    retire = 1'b1;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    if (retire) state_d = run ? StFetch : StIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      reg_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && step_ok) ir_q <= instr_in;
      if (retire) begin
        pc_q <= next_pc;
        if (retired_q != '1) retired_q <= retired_q + CNT_W'(1);
      end
      reg_we_q <= (state_d == StWb);
      // Memory strobes latch on MEM entry and stay frozen until the access completes.
      if (state_d != StMem) begin
        mem_re_q <= 1'b0;
        mem_we_q <= 1'b0;
      end else if (state_q != StMem) begin
        mem_re_q <= ctl_mem_read;
        mem_we_q <= ctl_mem_write;
      end
      busy_q   <= !(state_d inside {StIdle, StHalt});
      halted_q <= (state_d == StHalt);
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign reg_we  = reg_we_q;
  assign mem_re  = mem_re_q;
  assign mem_we  = mem_we_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule
